// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, fixed-latency unified memory between the
// instruction-fetch requester (IF) and the memory-access requester (MEM).
// One command is outstanding at a time. Each access runs the sequence
// IDLE -> ISSUE -> WAIT* -> CAPTURE -> ACK. The owner gets a one-cycle ack with
// its read data. MEM normally wins arbitration. IF is forced through after
// STARVE_LIMIT consecutive MEM grants that were made while IF was waiting.
//
// Parameters
//   ADDR_W        address width
//   DATA_W        data width
//   LATENCY       cycles from ram_en to valid ram_rdata (1..15)
//   STARVE_LIMIT  MEM grants tolerated while IF waits (1..15)
//
// Ports
//   Clk, Reset            rising-edge clock, synchronous active-low reset
//   if_req/if_addr        IF read request, held until if_ack
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata
//                         MEM request, held until mem_ack
//   ram_en/ram_we/ram_be/ram_addr/ram_wdata
//                         registered command to the memory macro
//   ram_rdata             memory read data, valid LATENCY cycles after ram_en
//   if_ack/if_rdata       IF completion pulse and fetched word
//   mem_ack/mem_rdata     MEM completion pulse and load data (0 for writes)
//   stall_if/stall_mem    combinational freeze requests to the hazard unit
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_be,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,

    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        ACK
    } state_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_t;

    // The wait counter is loaded in ISSUE, so it counts the remaining
    // LATENCY-1 cycles until ram_rdata is valid.
    localparam logic [3:0] WAIT_LOAD  = 4'(LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state;
    owner_t     owner;
    logic       owner_we;     // the access in flight is a MEM write
    logic [3:0] wait_cnt;
    logic [3:0] starve_cnt;
    logic       grant_if;

    // IF wins when it is alone, or when MEM has starved it long enough.
    assign grant_if  = if_req & (~mem_req | (starve_cnt == STARVE_MAX));

    // The stalls follow the request inputs combinationally, so a requester
    // is frozen from the cycle it asks until the cycle it sees its ack.
    assign stall_if  = if_req  & ~if_ack;
    assign stall_mem = mem_req & ~mem_ack;

    always_ff @(posedge Clk) begin
        // NOTE: The reset is synchronous and clears every output register,
        // so no ack or command can come out of an access that reset aborted.
        if (!Reset) begin
            state      <= IDLE;
            owner      <= OWNER_IF;
            owner_we   <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_be     <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_ack     <= 1'b0;
            if_rdata   <= '0;
            mem_ack    <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            // NOTE: Strobes default low here and are raised only in the
            // state that owns them. This keeps each one to one cycle, and
            // every state assignment in this block is non-blocking.
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (if_req || mem_req) begin
                        // Register the winner's command now so it is on the
                        // ram_* pins during the ISSUE cycle.
                        state  <= ISSUE;
                        ram_en <= 1'b1;
                        if (grant_if) begin
                            owner      <= OWNER_IF;
                            owner_we   <= 1'b0;
                            ram_we     <= 1'b0;
                            ram_be     <= 4'hF;
                            ram_addr   <= if_addr;
                            ram_wdata  <= '0;
                            starve_cnt <= '0;
                        end else begin
                            owner     <= OWNER_MEM;
                            owner_we  <= mem_we;
                            ram_we    <= mem_we;
                            ram_be    <= mem_we ? mem_be : 4'hF;
                            ram_addr  <= mem_addr;
                            ram_wdata <= mem_we ? mem_wdata : '0;
                            // Count only the MEM grants that made IF wait.
                            if (!if_req) begin
                                starve_cnt <= '0;
                            end else if (starve_cnt != STARVE_MAX) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end
                    end
                end

                ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                    if (LATENCY == 1) begin
                        state <= CAPTURE;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    // Leave when this decrement brings the counter to zero.
                    // The CAPTURE cycle is then LATENCY cycles after ram_en.
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    state <= ACK;
                    if (owner == OWNER_IF) begin
                        if_rdata <= ram_rdata;
                        if_ack   <= 1'b1;
                    end else begin
                        mem_rdata <= owner_we ? '0 : ram_rdata;
                        mem_ack   <= 1'b1;
                    end
                end

                ACK: begin
                    // No arbitration here. The requester that was just acked
                    // still shows req this cycle and must not be granted again.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. One instance uses LATENCY=2 and sits in
// front of a behavioural byte-enable memory. A second instance uses LATENCY=1.
// Requests are queued per requester together with their expected read data and
// the expected ack cycle. A requester keeps its req high while its queue holds
// entries. Each ack pops the front entry and compares against it.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT   = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT (LATENCY = 2) ----------------
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        if_ack, mem_ack, stall_if, stall_mem;
    logic [31:0] if_rdata, mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .Clk(clk), .Reset(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    // ---------------- second DUT (LATENCY = 1) ----------------
    logic        if_req_l1;
    logic [31:0] if_addr_l1;
    logic        ram_en_l1, ram_we_l1;
    logic [3:0]  ram_be_l1;
    logic [31:0] ram_addr_l1, ram_wdata_l1, ram_rdata_l1;
    logic        if_ack_l1, mem_ack_l1, stall_if_l1, stall_mem_l1;
    logic [31:0] if_rdata_l1, mem_rdata_l1;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LATENCY(1), .STARVE_LIMIT(LIMIT)
    ) dut_l1 (
        .Clk(clk), .Reset(rst_n),
        .if_req(if_req_l1), .if_addr(if_addr_l1),
        .mem_req(1'b0), .mem_we(1'b0), .mem_be(4'h0),
        .mem_addr(32'h0), .mem_wdata(32'h0),
        .ram_en(ram_en_l1), .ram_we(ram_we_l1), .ram_be(ram_be_l1),
        .ram_addr(ram_addr_l1), .ram_wdata(ram_wdata_l1), .ram_rdata(ram_rdata_l1),
        .if_ack(if_ack_l1), .if_rdata(if_rdata_l1),
        .mem_ack(mem_ack_l1), .mem_rdata(mem_rdata_l1),
        .stall_if(stall_if_l1), .stall_mem(stall_mem_l1)
    );

    // ---------------- helpers ----------------
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ---------------- behavioural memory for the main DUT ----------------
    logic [31:0] ram    [0:255];
    bit          ram_wr [0:255];
    logic [31:0] rd_pipe [1:15];

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_wr[a[7:0]] ? ram[a[7:0]] : init_word(a);
    endfunction

    // Read data is valid exactly LAT cycles after the ram_en cycle and is
    // garbage at every other time.
    always @(posedge clk) begin
        rd_pipe[1] <= 32'hBAD0_0BAD;
        if (ram_en) begin
            if (ram_we) begin
                ram[ram_addr[7:0]]    <= merge(ram_rd(ram_addr), ram_wdata, ram_be);
                ram_wr[ram_addr[7:0]] <= 1'b1;
            end else begin
                rd_pipe[1] <= ram_rd(ram_addr);
            end
        end
        for (int k = 2; k <= 15; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign ram_rdata = rd_pipe[LAT];

    // ---------------- memory for the LATENCY=1 DUT ----------------
    logic [31:0] rd_l1;
    always @(posedge clk) rd_l1 <= ram_en_l1 ? init_word(ram_addr_l1) : 32'hBAD1_1BAD;
    assign ram_rdata_l1 = rd_l1;

    // ---------------- reference memory and scoreboards ----------------
    logic [31:0] exp_mem [0:255];
    bit          exp_wr  [0:255];

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return exp_wr[a[7:0]] ? exp_mem[a[7:0]] : init_word(a);
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          due;
    } txn_t;

    txn_t sb_if[$];
    txn_t sb_mem[$];
    txn_t sb_l1[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    int          en_count, first_en;
    logic        first_we;
    logic [3:0]  first_be;
    logic [31:0] first_addr, first_wdata;
    bit          stall_chk = 1'b0;
    int          stall_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    task automatic check_true(input string tag, input bit cond);
        n_checks++;
        assert (cond) n_pass++;
        else $error("FAIL %s: condition false", tag);
    endtask

    task automatic push_if(input logic [31:0] a, input int due);
        txn_t t;
        t.addr = a; t.we = 1'b0; t.be = 4'hF; t.wdata = '0;
        t.exp = exp_rd(a); t.due = due;
        sb_if.push_back(t);
    endtask

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, input int due);
        txn_t t;
        t.addr = a; t.we = we; t.be = be; t.wdata = wd; t.due = due;
        if (we) begin
            t.exp = '0;
            exp_mem[a[7:0]] = merge(exp_rd(a), wd, be);
            exp_wr[a[7:0]]  = 1'b1;
        end else begin
            t.exp = exp_rd(a);
        end
        sb_mem.push_back(t);
    endtask

    task automatic drive_if();
        if (sb_if.size() != 0) begin
            if_req = 1'b1; if_addr = sb_if[0].addr;
        end else begin
            if_req = 1'b0; if_addr = '0;
        end
    endtask

    task automatic drive_mem();
        if (sb_mem.size() != 0) begin
            mem_req = 1'b1; mem_addr = sb_mem[0].addr; mem_we = sb_mem[0].we;
            mem_be = sb_mem[0].be; mem_wdata = sb_mem[0].wdata;
        end else begin
            mem_req = 1'b0; mem_addr = '0; mem_we = 1'b0; mem_be = '0; mem_wdata = '0;
        end
    endtask

    task automatic reset_stats();
        en_count = 0; first_en = -1; first_we = 1'b0; first_be = '0;
        first_addr = '0; first_wdata = '0;
    endtask

    // Advance n cycles. Outputs are sampled at the falling edge, acks are
    // scored, and each requester is re-driven from its queue.
    task automatic run(input int n);
        txn_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (ram_en) begin
                en_count++;
                if (en_count == 1) begin
                    first_en = cyc; first_we = ram_we; first_be = ram_be;
                    first_addr = ram_addr; first_wdata = ram_wdata;
                end
            end
            if (stall_chk && cyc <= stall_last)
                check("stall_if", {31'b0, stall_if}, {31'b0, (cyc < stall_last)});
            if (if_ack || mem_ack)
                check_true("single_owner", !(if_ack && mem_ack));
            if (if_ack) begin
                check_true("if_ack_expected", sb_if.size() != 0);
                if (sb_if.size() != 0) begin
                    e = sb_if.pop_front();
                    check("if_rdata", if_rdata, e.exp);
                    check("if_ack_cycle", 32'(cyc), 32'(e.due));
                end
                drive_if();
            end
            if (mem_ack) begin
                check_true("mem_ack_expected", sb_mem.size() != 0);
                if (sb_mem.size() != 0) begin
                    e = sb_mem.pop_front();
                    check("mem_rdata", mem_rdata, e.exp);
                    check("mem_ack_cycle", 32'(cyc), 32'(e.due));
                end
                drive_mem();
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          ack_cyc_l1, en_cyc_l1, ack_cnt_l1;
        logic [31:0] data_l1;
        txn_t        e;

        rst_n = 1'b0;
        if_req_l1 = 1'b0; if_addr_l1 = '0;
        reset_stats();
        cyc = 0;

        // Reset held for two cycles while IF is requesting.
        push_if(32'h10, 4);
        drive_if();
        drive_mem();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            check("rst_ram_en", {31'b0, ram_en}, 32'd0);
            check("rst_ctl", {25'b0, ram_we, if_ack, mem_ack, ram_be}, 32'd0);
            check("rst_ram_addr", ram_addr, 32'd0);
            check("rst_ram_wdata", ram_wdata, 32'd0);
            check("rst_rdata", if_rdata | mem_rdata, 32'd0);
            check("rst_stalls", {30'b0, stall_if, stall_mem}, 32'd2);
        end
        rst_n = 1'b1;
        cyc = 0;
        run(8);
        check("t1_first_en", 32'(first_en), 32'd1);
        check("t1_addr", first_addr, 32'h10);
        check("t1_be", {27'b0, first_we, first_be}, 32'h0F);
        check("t1_en_count", 32'(en_count), 32'd1);
        check("t1_drained", 32'(sb_if.size()), 32'd0);

        // Both requesters at once: MEM first, then IF; IF stalled through cycle 8.
        reset_stats();
        cyc = 0;
        push_mem(32'h20, 1'b0, 4'hF, 32'h0, 4);
        push_if(32'h30, 9);
        drive_mem();
        drive_if();
        #1;
        check("t2_stall_c0", {31'b0, stall_if}, 32'd1);
        stall_chk = 1'b1; stall_last = 9;
        run(12);
        stall_chk = 1'b0;
        check("t2_first_addr", first_addr, 32'h20);
        check("t2_en_count", 32'(en_count), 32'd2);
        check("t2_drained", 32'(sb_if.size() + sb_mem.size()), 32'd0);

        // Partial write, then read-back of the merged word. Inputs are
        // scrambled after the grant to show they are no longer sampled.
        reset_stats();
        cyc = 0;
        push_mem(32'h40, 1'b1, 4'b0011, 32'hDEAD_BEEF, 4);
        push_mem(32'h40, 1'b0, 4'hF, 32'h0, 9);
        drive_mem();
        run(1);
        mem_addr = 32'h41; mem_wdata = 32'hFFFF_FFFF; mem_be = 4'hF;
        run(11);
        check("t3_we", {31'b0, first_we}, 32'd1);
        check("t3_be", {28'b0, first_be}, 32'h3);
        check("t3_addr", first_addr, 32'h40);
        check("t3_wdata", first_wdata, 32'hDEAD_BEEF);
        check("t3_en_count", 32'(en_count), 32'd2);
        check("t3_drained", 32'(sb_mem.size()), 32'd0);

        // Starvation: MEM re-requests back to back while IF waits. IF wins the
        // 5th grant, and after the counter restarts IF waits 4 more grants.
        reset_stats();
        cyc = 0;
        push_if(32'h50, 24);
        push_if(32'h54, 49);
        push_mem(32'h60, 1'b0, 4'hF, 0, 4);
        push_mem(32'h61, 1'b0, 4'hF, 0, 9);
        push_mem(32'h62, 1'b0, 4'hF, 0, 14);
        push_mem(32'h63, 1'b0, 4'hF, 0, 19);
        push_mem(32'h64, 1'b0, 4'hF, 0, 29);
        push_mem(32'h65, 1'b0, 4'hF, 0, 34);
        push_mem(32'h66, 1'b0, 4'hF, 0, 39);
        push_mem(32'h67, 1'b0, 4'hF, 0, 44);
        push_mem(32'h68, 1'b0, 4'hF, 0, 54);
        drive_if();
        drive_mem();
        run(60);
        check("t4_en_count", 32'(en_count), 32'd11);
        check("t4_drained", 32'(sb_if.size() + sb_mem.size()), 32'd0);

        // Reset during WAIT aborts the read. It is re-issued once reset lifts.
        reset_stats();
        cyc = 0;
        push_mem(32'h70, 1'b0, 4'hF, 0, 7);
        drive_mem();
        run(2);
        rst_n = 1'b0;
        run(1);
        check("t5_rst_en", {31'b0, ram_en}, 32'd0);
        check("t5_rst_ack", {30'b0, if_ack, mem_ack}, 32'd0);
        check("t5_rst_addr", ram_addr, 32'd0);
        check("t5_rst_rdata", mem_rdata, 32'd0);
        rst_n = 1'b1;
        run(8);
        check("t5_en_count", 32'(en_count), 32'd2);
        check("t5_drained", 32'(sb_mem.size()), 32'd0);

        // LATENCY=1 build: ISSUE goes straight to CAPTURE, so the ack comes on cycle 3.
        begin
            txn_t t;
            t.addr = 32'h88; t.we = 1'b0; t.be = 4'hF; t.wdata = '0;
            t.exp = init_word(32'h88); t.due = 3;
            sb_l1.push_back(t);
        end
        if_req_l1 = 1'b1; if_addr_l1 = 32'h88;
        ack_cyc_l1 = -1; en_cyc_l1 = -1; ack_cnt_l1 = 0; data_l1 = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ram_en_l1) en_cyc_l1 = i;
            if (if_ack_l1) begin
                ack_cnt_l1++;
                ack_cyc_l1 = i;
                data_l1 = if_rdata_l1;
                if_req_l1 = 1'b0;
            end
        end
        check("l1_en_cycle", 32'(en_cyc_l1), 32'd1);
        check("l1_ack_count", 32'(ack_cnt_l1), 32'd1);
        check_true("l1_sb_nonempty", sb_l1.size() != 0);
        if (sb_l1.size() != 0) begin
            e = sb_l1.pop_front();
            check("l1_ack_cycle", 32'(ack_cyc_l1), 32'(e.due));
            check("l1_rdata", data_l1, e.exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbiter/sequencer that shares one single-ported, fixed-latency unified memory between the instruction-fetch stage (IF requester) and the memory-access stage (MEM requester).
- Sits between the pipeline stages and the memory macro.
- Issues one memory command at a time and returns read data with a one-cycle ack.
- Drives per-requester stall lines that the hazard unit uses to freeze PC, IF/ID and EX/MEM.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 2, cycles from the memory command to ram_rdata valid; legal range is 1..15.
- STARVE_LIMIT, 4, consecutive MEM grants while IF waits before IF is forced a grant; legal range is 1..15.

Ports:
- Clk  in  1  clock; all logic rising-edge.
- Reset  in  1  synchronous, active-low reset.
- if_req  in  1  IF read request; held high until if_ack.
- if_addr  in  ADDR_W  IF word address.
- mem_req  in  1  MEM request; held high until mem_ack.
- mem_we  in  1  1 = write, 0 = read.
- mem_be  in  4  write byte enables.
- mem_addr  in  ADDR_W  MEM address.
- mem_wdata  in  DATA_W  MEM write data.
- ram_en  out  1  command strobe.
- ram_we  out  1  write command.
- ram_be  out  4  byte enables to the memory.
- ram_addr  out  ADDR_W  address to the memory.
- ram_wdata  out  DATA_W  write data to the memory.
- ram_rdata  in  DATA_W  memory read data, valid LATENCY cycles after ram_en.
- if_ack  out  1  one-cycle completion pulse for IF.
- if_rdata  out  DATA_W  fetched word, valid while if_ack.
- mem_ack  out  1  one-cycle completion pulse for MEM.
- mem_rdata  out  DATA_W  load data, valid while mem_ack; 0 for writes.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_mem  out  1  mem_req & ~mem_ack (combinational).

Behaviour:
- Reset (Reset == 0 at a rising edge):
  - Next state is IDLE.
  - ram_en, ram_we, if_ack and mem_ack are 0.
  - ram_be, ram_addr, ram_wdata, if_rdata and mem_rdata are 0.
  - The wait counter, starvation counter and owner register clear.
  - Reset mid-operation aborts the in-flight access; no ack is produced for it, and any late ram_rdata is ignored.
- FSM IDLE:
  - If no request, stay in IDLE.
  - Otherwise pick the winner, register its address, write data and byte enables into the ram_* outputs, and go to ISSUE.
- Winner selection:
  - MEM wins by default.
  - IF wins if only if_req is high.
  - IF also wins if both requests are high and starve_cnt == STARVE_LIMIT.
- FSM ISSUE (one cycle):
  - ram_en = 1.
  - ram_we = mem_we if owner = MEM, else 0.
  - ram_be = mem_be for a MEM write, else 4'hF.
  - Load the wait counter with LATENCY−1 and go to WAIT. If LATENCY == 1, go straight to CAPTURE.
- FSM WAIT:
  - ram_en = 0; decrement the counter.
  - When the counter reaches 0, go to CAPTURE.
- FSM CAPTURE (the cycle ram_rdata is valid):
  - Register ram_rdata into the owner's rdata (0 for a write) and go to ACK.
- FSM ACK (one cycle):
  - Owner's ack = 1; go to IDLE.
  - No arbitration happens in ACK, so a requester's still-high req is not re-granted.
- Timing:
  - With the request first seen in IDLE cycle 0, ram_en is high in cycle 1 and ack is high in cycle LATENCY+2.
  - The next grant is decided in cycle LATENCY+3.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each MEM grant while if_req is high.
  - Clears on an IF grant, or on a MEM grant while if_req is low.
- Write ordering: writes and reads are never reordered.
- Input sampling:
  - Request inputs are sampled only in IDLE.
  - Changes to address or data after the grant are ignored.
- Output hold: if_rdata and mem_rdata hold their last value outside ack; only the ack qualifies them.
- Single owner: if_ack and mem_ack are never high together, and at most one command is outstanding.

Test Plan:
- Reset low for 2 cycles with if_req=1 → all outputs 0 and no ram_en. Release reset → ram_en in the cycle after the first IDLE, then if_ack at +4 cycles (LATENCY=2), with if_rdata = the memory word.
- if_req and mem_req (read) both high at cycle 0 → MEM is granted first, mem_ack at cycle 4. IF is granted at cycle 5, if_ack at cycle 9. stall_if stays 1 during cycles 0–8.
- MEM write, mem_addr=0x40, mem_be=4'b0011, mem_wdata=0xDEADBEEF → single ram_en cycle with ram_we=1, ram_be=0011, and mem_ack with mem_rdata=0. A following MEM read of 0x40 returns the memory's merged word.
- MEM held continuously busy (re-requesting immediately after each ack) while if_req stays high → after 4 MEM grants the 5th grant goes to IF, then the counter restarts.
- Reset asserted during WAIT → no ack is produced, the FSM is in IDLE at the next cycle, and the pending request is re-issued after reset is released.
- LATENCY=1 build → ISSUE goes straight to CAPTURE, and the ack comes 3 cycles after the request is seen.
